// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared FSM encoding, cycle count and ALU control codes for the divider
package div_unit_pkg;
  localparam int DIV_CYCLES = 32;
  localparam logic [3:0] ALU_DIV  = 4'hA;
  localparam logic [3:0] ALU_DIVU = 4'hB;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: EX-stage divider request/response bundle
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
);
  logic start, signed_div, annul, div_stall, ready;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] result;
  modport master(output start, signed_div, annul, a, b, input div_stall, ready, result);
  modport slave(input start, signed_div, annul, a, b, output div_stall, ready, result);
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division step on {rem, quo}
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem_n,
  output logic [WIDTH-1:0] o_quo_n
);
  logic [WIDTH:0] w_t, w_d;
  always_comb begin
    w_t = {i_rem, i_quo[WIDTH-1]};
    w_d = w_t - {1'b0, i_div};
    o_rem_n = w_d[WIDTH] ? w_t[WIDTH-1:0] : w_d[WIDTH-1:0];
    o_quo_n = {i_quo[WIDTH-2:0], ~w_d[WIDTH]};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU with EX-stage stall
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES
) (
  input logic clk,
  input logic rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  div_state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_div, w_rem_n, w_quo_n, w_abs_a, w_abs_b, w_q, w_r;
  logic [2*WIDTH-1:0] r_result;
  logic r_sa, r_sb, r_bz, w_sa, w_sb, w_last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem(r_rem), .i_quo(r_quo), .i_div(r_div), .o_rem_n(w_rem_n), .o_quo_n(w_quo_n)
  );
  // b==0 falls out of the unsigned iteration as rem=|a|, quo=all ones; only the quotient needs forcing
  always_comb begin
    w_sa = bus.signed_div & bus.a[WIDTH-1];
    w_sb = bus.signed_div & bus.b[WIDTH-1];
    w_abs_a = w_sa ? -bus.a : bus.a;
    w_abs_b = w_sb ? -bus.b : bus.b;
    w_last = (r_state == DIV_BUSY) && (r_cnt == CW'(WIDTH - 1));
    w_q = r_bz ? '1 : (r_sa ^ r_sb) ? -w_quo_n : w_quo_n;
    w_r = r_sa ? -w_rem_n : w_rem_n;
    w_next = bus.annul ? DIV_IDLE :
             r_state == DIV_IDLE ? (bus.start ? DIV_BUSY : DIV_IDLE) :
             r_state == DIV_BUSY ? (w_last ? DIV_DONE : DIV_BUSY) : DIV_IDLE;
  end
  assign bus.div_stall = (((r_state == DIV_IDLE) & bus.start) | (r_state == DIV_BUSY)) & ~bus.annul & ~rst;
  assign bus.ready = (r_state == DIV_DONE) & ~bus.annul & ~rst;
  assign bus.result = r_result;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt <= '0;
      r_result <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      r_bz <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DIV_IDLE) begin
        r_rem <= '0;
        r_quo <= w_abs_a;
        r_div <= w_abs_b;
        r_sa <= w_sa;
        r_sb <= w_sb;
        r_bz <= (bus.b == '0);
        r_cnt <= '0;
      end else if (r_state == DIV_BUSY) begin
        r_rem <= w_rem_n;
        r_quo <= w_quo_n;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_last && !bus.annul) r_result <= {w_r, w_q};
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed divider vectors with a queued scoreboard checked on every ready pulse
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;
  div_unit_if #(.WIDTH(32)) bus ();
  div_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.ready) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 64'd1, 64'd0);
      else chk("result", bus.result, exp_q.pop_front());
    end
  end

  // called #1 after a posedge; leaves control #1 after the posedge following ready
  task automatic do_div(input logic sg, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] res, input logic keep);
    int cyc, stalls;
    logic got;
    bus.start = 1'b1;
    bus.signed_div = sg;
    bus.a = av;
    bus.b = bv;
    exp_q.push_back(res);
    cyc = 0;
    stalls = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
      if (bus.div_stall) stalls++;
      if (i == 1) begin
        bus.a = ~av;
        bus.b = bv ^ 32'h5A5A_5A5A;
      end
    end
    if (!got) chk("ready_timeout", 64'd0, 64'd1);
    else begin
      chk("stall_cycles", 64'(stalls), 64'd33);
      chk("ready_cycle", 64'(cyc), 64'd34);
      chk("stall_at_ready", 64'(bus.div_stall), 64'd0);
      last_res = res;
    end
    @(posedge clk);
    #1;
    if (!keep) bus.start = 1'b0;
  endtask

  initial begin
    logic seen_ready;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.annul = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'd0);
    chk("rst_stall", 64'(bus.div_stall), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    do_div(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);
    do_div(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1);
    do_div(1'b1, -32'sd8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF}, 1'b1);
    do_div(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 1'b1);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2, {32'd1, 32'h7FFF_FFFC}, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b0);
    // annul during BUSY cycle 10
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("annul_stall", 64'(bus.div_stall), 64'd0);
    @(posedge clk);
    #1;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("post_annul_stall", 64'(bus.div_stall), 64'd0);
    seen_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_ready |= bus.ready;
    end
    chk("annul_no_ready", 64'(seen_ready), 64'd0);
    chk("annul_result_held", bus.result, last_res);
    // reset during BUSY cycle 20
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("midrst_stall", 64'(bus.div_stall), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_idle_stall", 64'(bus.div_stall), 64'd0);
    @(posedge clk);
    #1;
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);
    repeat (5) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
